// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants shared by the sync generators and the sync decoder.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned H_FRONT_PORCH = 16;
  localparam int unsigned H_SYNC_PULSE  = 96;
  localparam int unsigned H_BACK_PORCH  = 48;
  localparam int unsigned H_TOTAL       = 800;

  localparam int unsigned V_ACTIVE      = 480;
  localparam int unsigned V_FRONT_PORCH = 10;
  localparam int unsigned V_SYNC_PULSE  = 2;
  localparam int unsigned V_BACK_PORCH  = 33;
  localparam int unsigned V_TOTAL       = 525;

  localparam int unsigned LOCK_LINES    = 4;

  // hSync is low for pixels HS_START .. HS_END-1
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT_PORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNC_PULSE;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/vga_sync_edge_detect.sv
// Samples one active-low sync line on pix_en and flags its falling/rising edges.
module vga_sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync_n,
  output logic fall_c,
  output logic rise_c
);

  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
    end else if (pix_en) begin
      sync_q <= sync_n;
    end
  end

  assign fall_c = pix_en & sync_q & ~sync_n;
  assign rise_c = pix_en & ~sync_q & sync_n;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds raster counters from hSync/vSync edges and tracks horizontal lock.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE      = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT_PORCH = vga_timing_pkg::H_FRONT_PORCH,
  parameter int unsigned H_SYNC_PULSE  = vga_timing_pkg::H_SYNC_PULSE,
  parameter int unsigned H_TOTAL       = vga_timing_pkg::H_TOTAL,
  parameter int unsigned V_ACTIVE      = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT_PORCH = vga_timing_pkg::V_FRONT_PORCH,
  parameter int unsigned V_TOTAL       = vga_timing_pkg::V_TOTAL,
  parameter int unsigned LOCK_LINES    = vga_timing_pkg::LOCK_LINES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_en,
  input  logic                       h_sync_n,
  input  logic                       v_sync_n,
  output logic [$clog2(H_TOTAL)-1:0] h_count,
  output logic [$clog2(V_TOTAL)-1:0] v_count,
  output logic                       active,
  output logic                       locked,
  output logic                       sync_err,
  output logic                       frame_start
);

  import vga_timing_pkg::*;

  localparam int unsigned HW  = $clog2(H_TOTAL);
  localparam int unsigned VW  = $clog2(V_TOTAL);
  localparam int unsigned WDW = $clog2(2 * H_TOTAL);
  localparam int unsigned GW  = $clog2(LOCK_LINES + 1);

  localparam int unsigned H_LOAD     = H_ACTIVE + H_FRONT_PORCH;
  localparam int unsigned H_RISE_PRE = H_LOAD + H_SYNC_PULSE - 1;
  localparam int unsigned V_LOAD     = V_ACTIVE + V_FRONT_PORCH;
  localparam int unsigned WD_LAST    = 2 * H_TOTAL - 1;

  logic h_fall;
  logic h_rise;
  logic v_fall;
  logic v_rise_unused;

  vga_sync_edge_detect u_h_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync_n (h_sync_n),
    .fall_c (h_fall),
    .rise_c (h_rise)
  );

  vga_sync_edge_detect u_v_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync_n (v_sync_n),
    .fall_c (v_fall),
    .rise_c (v_rise_unused)
  );

  lock_state_t    state;
  lock_state_t    state_nx;
  logic [GW-1:0]  good;
  logic [GW-1:0]  good_nx;
  logic [WDW-1:0] wd;
  logic [WDW-1:0] wd_nx;
  logic           err_nx;

  logic [HW-1:0]  h_next;
  logic [VW-1:0]  v_next;
  logic           h_at_end;
  logic           h_wrap;
  logic           fall_good;
  logic           viol;
  logic           wd_expire;

  // Counter prediction: an h fall re-anchors the line, otherwise free-run
  always_comb begin
    h_at_end  = (h_count == HW'(H_TOTAL - 1));
    h_wrap    = pix_en & ~h_fall & h_at_end;
    fall_good = h_fall & (h_count == HW'(H_LOAD - 1));
    viol      = (h_fall & ~fall_good) | (h_rise & (h_count != HW'(H_RISE_PRE)));
    wd_expire = pix_en & ~h_fall & (wd == WDW'(WD_LAST));

    if (h_fall) begin
      h_next = HW'(H_LOAD);
    end else if (h_at_end) begin
      h_next = '0;
    end else begin
      h_next = h_count + HW'(1);
    end

    if (v_fall) begin
      v_next = VW'(V_LOAD);
    end else if (h_wrap) begin
      v_next = (v_count == VW'(V_TOTAL - 1)) ? '0 : v_count + VW'(1);
    end else begin
      v_next = v_count;
    end
  end

  // Lock tracking; the watchdog only runs while a lock is being tracked
  always_comb begin
    state_nx = state;
    good_nx  = good;
    wd_nx    = wd;
    err_nx   = 1'b0;

    if (pix_en) begin
      wd_nx = (h_fall || state == SEARCH) ? '0 : wd + WDW'(1);

      unique case (state)
        SEARCH: begin
          if (h_fall) begin
            state_nx = TRACK;
            good_nx  = '0;
          end
        end
        TRACK: begin
          if (viol) begin
            err_nx  = 1'b1;
            good_nx = '0;
          end else if (fall_good) begin
            if (good == GW'(LOCK_LINES - 1)) begin
              state_nx = LOCKED;
              good_nx  = '0;
            end else begin
              good_nx = good + GW'(1);
            end
          end
        end
        LOCKED: begin
          if (viol) begin
            err_nx   = 1'b1;
            state_nx = TRACK;
            good_nx  = '0;
          end
        end
        default: begin
          state_nx = SEARCH;
          good_nx  = '0;
        end
      endcase

      if (state != SEARCH && wd_expire) begin
        state_nx = SEARCH;
        good_nx  = '0;
        wd_nx    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      good        <= '0;
      wd          <= '0;
      h_count     <= '0;
      v_count     <= '0;
      active      <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sync_err    <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        state       <= state_nx;
        good        <= good_nx;
        wd          <= wd_nx;
        h_count     <= h_next;
        v_count     <= v_next;
        locked      <= (state_nx == LOCKED);
        active      <= (state_nx == LOCKED) && (h_next < HW'(H_ACTIVE)) &&
                       (v_next < VW'(V_ACTIVE));
        sync_err    <= err_nx;
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized bench for vga_sync_decoder against a behavioural raster/lock model.
module tb_vga_sync_decoder;

  localparam int HA  = 640;
  localparam int HFP = 16;
  localparam int HSP = 96;
  localparam int HT  = 800;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VSP = 2;
  localparam int VT  = 20;
  localparam int LL  = 4;
  localparam int HW  = $clog2(HT);
  localparam int VW  = $clog2(VT);
  localparam int VECW = HW + VW + 4;

  logic          clk;
  logic          rst_n;
  logic          pix_en;
  logic          h_sync_n;
  logic          v_sync_n;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          active;
  logic          locked;
  logic          sync_err;
  logic          frame_start;

  wire [VECW-1:0] obs = {h_count, v_count, active, locked, sync_err, frame_start};

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_TOTAL(VT), .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_sync_n(h_sync_n), .v_sync_n(v_sync_n),
    .h_count(h_count), .v_count(v_count), .active(active), .locked(locked),
    .sync_err(sync_err), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference raster generator
  int g_h, g_v;
  bit g_long, g_short, g_hold, rnd_lines, rnd_glitch;
  int s_h, s_v;
  bit prev_hs, tb_hfall, tb_hrise;

  // Behavioural decoder model: 0=search, 1=track, 2=locked
  int m_hs_q, m_vs_q, m_h, m_v, m_st, m_good, m_since;
  bit m_active, m_locked, m_err, m_fs;

  function automatic bit gen_hs();
    int pw = g_short ? HSP - 1 : HSP;
    return !(g_h >= HA + HFP && g_h < HA + HFP + pw);
  endfunction

  function automatic bit gen_vs();
    return !(g_v >= VA + VFP && g_v < VA + VFP + VSP);
  endfunction

  task automatic gen_advance();
    int last = g_long ? HT : HT - 1;
    if (g_h >= last) begin
      g_h = 0;
      g_v = (g_v + 1) % VT;
      g_long = 0;
      g_short = 0;
      if (rnd_lines) begin
        g_long  = ($urandom_range(0, 9) == 0);
        g_short = ($urandom_range(0, 9) == 0);
      end
    end else begin
      g_h++;
    end
  endtask

  task automatic model_reset();
    m_hs_q = 1; m_vs_q = 1; m_h = 0; m_v = 0; m_st = 0; m_good = 0; m_since = 0;
    m_active = 0; m_locked = 0; m_err = 0; m_fs = 0;
  endtask

  task automatic model_step(input bit pe, input bit hs, input bit vs);
    bit fall, rise, vfall, viol;
    int ph, st0;
    m_err = 0;
    m_fs  = 0;
    if (!pe) return;
    fall  = (m_hs_q == 1) && !hs;
    rise  = (m_hs_q == 0) && hs;
    vfall = (m_vs_q == 1) && !vs;
    m_hs_q = int'(hs);
    m_vs_q = int'(vs);
    ph = m_h;
    if (fall) m_h = HA + HFP;
    else m_h = (ph + 1) % HT;
    if (vfall) m_v = VA + VFP;
    else if (!fall && ph == HT - 1) m_v = (m_v + 1) % VT;
    viol = (fall && ph != HA + HFP - 1) || (rise && ph != HA + HFP + HSP - 1);
    st0 = m_st;
    if (fall || st0 == 0) m_since = 0;
    else m_since++;
    if (st0 == 0) begin
      if (fall) begin m_st = 1; m_good = 0; end
    end else begin
      if (viol) begin
        m_err = 1; m_st = 1; m_good = 0;
      end else if (fall && st0 == 1) begin
        m_good++;
        if (m_good == LL) m_st = 2;
      end
      if (m_since >= 2 * HT) begin m_st = 0; m_good = 0; m_since = 0; end
    end
    m_locked = (m_st == 2);
    m_active = m_locked && m_h < HA && m_v < VA;
    m_fs = (m_h == 0) && (m_v == 0);
  endtask

  function automatic logic [VECW-1:0] exp_vec();
    return {HW'(m_h), VW'(m_v), m_active, m_locked, m_err, m_fs};
  endfunction

  // One clock: drive at negedge, update model and generator after the posedge
  task automatic tick(input bit pe);
    bit hs, vs;
    @(negedge clk);
    hs = g_hold ? 1'b1 : gen_hs();
    vs = gen_vs();
    if (rnd_glitch) begin
      if ($urandom_range(0, 1999) == 0) hs = ~hs;
      if ($urandom_range(0, 2999) == 0) vs = ~vs;
    end
    pix_en = pe; h_sync_n = hs; v_sync_n = vs;
    @(posedge clk);
    #1;
    tb_hfall = 0;
    tb_hrise = 0;
    if (!rst_n) begin
      model_reset();
      prev_hs = 1;
    end else begin
      if (pe) begin
        tb_hfall = prev_hs && !hs;
        tb_hrise = !prev_hs && hs;
        prev_hs = hs;
      end
      model_step(pe, hs, vs);
    end
    if (pe) begin
      s_h = g_h; s_v = g_v;
      gen_advance();
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL reset_values got=%h want=0", obs); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_hold got=%h want=%h", obs, exp_vec()); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    int falls = 0, fs_seen = 0, bad_here = 0;
    for (int c = 0; c < 6000 && falls < 5; c++) begin
      tick(1'b1);
      if (bad_here == 0) begin
        n_cmp++;
        if (obs !== exp_vec()) begin bad_here++; n_bad++; $display("FAIL clean_model c=%0d got=%h want=%h", c, obs, exp_vec()); end
      end
      if (tb_hfall) begin
        falls++;
        n_cmp++;
        if (locked !== (falls >= 5)) begin n_bad++; $display("FAIL clean_lock fall=%0d locked=%b want=%b", falls, locked, falls >= 5); end
      end
    end
    n_cmp++;
    if (falls < 5) begin n_bad++; $display("FAIL clean_timeout falls=%0d want=5", falls); end
    for (int c = 0; c < HT * VT; c++) begin
      tick(1'b1);
      if (frame_start) fs_seen++;
      if (bad_here == 0) begin
        n_cmp++;
        if ({h_count, v_count, locked} !== {HW'(s_h), VW'(s_v), 1'b1}) begin
          bad_here++; n_bad++;
          $display("FAIL clean_counters got=%0d,%0d,%b want=%0d,%0d,1", h_count, v_count, locked, s_h, s_v);
        end
        n_cmp++;
        if (obs !== exp_vec()) begin bad_here++; n_bad++; $display("FAIL clean_frame_model got=%h want=%h", obs, exp_vec()); end
      end
    end
    n_cmp++;
    if (fs_seen != 1) begin n_bad++; $display("FAIL frame_start_count got=%0d want=1", fs_seen); end
  endtask

  task automatic wait_fall(input string tag);
    int c = 0;
    do begin tick(1'b1); c++; end while (!tb_hfall && c < 3000);
    if (!tb_hfall) begin n_cmp++; n_bad++; $display("FAIL %s_no_fall waited=%0d", tag, c); end
  endtask

  task automatic relock_check(input string tag, input int need);
    for (int k = 1; k <= need; k++) begin
      wait_fall(tag);
      n_cmp++;
      if (locked !== (k == need)) begin n_bad++; $display("FAIL %s_relock fall=%0d locked=%b want=%b", tag, k, locked, k == need); end
    end
  endtask

  task automatic test_long_line();
    wait_fall("long");
    g_long = 1;
    wait_fall("long");
    n_cmp++;
    if ({h_count, sync_err, locked} !== {HW'(656), 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL long_line h=%0d err=%b locked=%b want h=656 err=1 locked=0", h_count, sync_err, locked);
    end
    n_cmp++;
    if (obs !== exp_vec()) begin n_bad++; $display("FAIL long_model got=%h want=%h", obs, exp_vec()); end
    relock_check("long", LL);
  endtask

  task automatic test_short_pulse();
    int c = 0;
    wait_fall("short");
    g_short = 1;
    do begin tick(1'b1); c++; end while (!tb_hrise && c < 2000);
    n_cmp++;
    if ({tb_hrise, h_count, sync_err, locked} !== {1'b1, HW'(751), 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL short_pulse rise=%b h=%0d err=%b locked=%b want 1 751 1 0", tb_hrise, h_count, sync_err, locked);
    end
    relock_check("short", LL);
  endtask

  task automatic test_watchdog();
    int c = 0, errs = 0, bad_here = 0;
    while (g_h != 0 && c < 2000) begin tick(1'b1); c++; end
    g_hold = 1;
    for (int i = 0; i < 2 * HT; i++) begin
      tick(1'b1);
      if (sync_err) errs++;
      if (bad_here == 0) begin
        n_cmp++;
        if (obs !== exp_vec()) begin bad_here++; n_bad++; $display("FAIL wd_model i=%0d got=%h want=%h", i, obs, exp_vec()); end
      end
    end
    g_hold = 0;
    n_cmp++;
    if ({locked, 8'(errs)} !== {1'b0, 8'd0}) begin n_bad++; $display("FAIL watchdog locked=%b errs=%0d want 0 0", locked, errs); end
    relock_check("wd", LL + 1);
  endtask

  task automatic test_random();
    int bad_here = 0, errs_dut = 0, errs_ref = 0;
    rnd_lines = 1; rnd_glitch = 1;
    for (int c = 0; c < 12000; c++) begin
      tick($urandom_range(0, 3) != 0);
      if (sync_err) errs_dut++;
      if (m_err) errs_ref++;
      if (bad_here == 0) begin
        n_cmp++;
        if (obs !== exp_vec()) begin bad_here++; n_bad++; $display("FAIL random_model c=%0d got=%h want=%h", c, obs, exp_vec()); end
      end
    end
    n_cmp++;
    if (errs_dut != errs_ref) begin n_bad++; $display("FAIL random_err_count got=%0d want=%0d", errs_dut, errs_ref); end
    rnd_lines = 0; rnd_glitch = 0; g_long = 0; g_short = 0;
  endtask

  task automatic test_pix_en_gating();
    int falls = 0, bad_here = 0, c = 0;
    rst_n = 1'b0;
    tick(1'b0);
    g_h = 0; g_v = 0; g_long = 0; g_short = 0;
    rst_n = 1'b1;
    while (falls < 5 && c < 12000) begin
      tick(c % 2 == 0);
      c++;
      if (bad_here == 0) begin
        n_cmp++;
        if (obs !== exp_vec()) begin bad_here++; n_bad++; $display("FAIL gate_model c=%0d got=%h want=%h", c, obs, exp_vec()); end
      end
      if (tb_hfall) begin
        falls++;
        n_cmp++;
        if (locked !== (falls >= 5)) begin n_bad++; $display("FAIL gate_lock fall=%0d locked=%b want=%b", falls, locked, falls >= 5); end
      end
    end
    n_cmp++;
    if (falls < 5) begin n_bad++; $display("FAIL gate_timeout falls=%0d want=5", falls); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    while (g_h != 100 && c < 2000) begin tick(1'b1); c++; end
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL mid_pre_locked got=%b want=1", locked); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    prev_hs = 1;
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL mid_async_reset got=%h want=0", obs); end
    for (int i = 0; i < 3; i++) tick(1'b1);
    n_cmp++;
    if (obs !== exp_vec()) begin n_bad++; $display("FAIL mid_reset_hold got=%h want=%h", obs, exp_vec()); end
    rst_n = 1'b1;
    relock_check("mid", LL + 1);
    n_cmp++;
    if (obs !== exp_vec()) begin n_bad++; $display("FAIL mid_model got=%h want=%h", obs, exp_vec()); end
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; h_sync_n = 1'b1; v_sync_n = 1'b1;
    g_h = 0; g_v = 0; g_long = 0; g_short = 0; g_hold = 0; rnd_lines = 0; rnd_glitch = 0;
    s_h = 0; s_v = 0; prev_hs = 1; tb_hfall = 0; tb_hrise = 0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_long_line();
    test_short_pulse();
    test_watchdog();
    test_random();
    test_pix_en_gating();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
